// File: rtl/npu_feed_pkg.sv
// Shared types and constants for the NPU feed controller slice.
// NPU_FEED_PERF_EN (optional) adds a stall counter to npu_feed_ctrl.
package npu_feed_pkg;

   localparam int CFG_BYTES = 8;
   localparam int CNT_W     = $clog2(CFG_BYTES);

   localparam logic MODE_CONV  = 1'b0;
   localparam logic MODE_DENSE = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      CFG_RD,
      CFG_WAIT,
      CFG_OUT,
      RD_A,
      RD_B,
      CAP,
      PRESENT,
      DONE
   } state_e;

endpackage

// File: rtl/npu_feed_cfg_shift.sv
// Serial-in, parallel-out filter-config register loaded byte by byte from conv RAM.
// cfg_bytes is the register's next value, so the final byte is visible in the load cycle.
module npu_feed_cfg_shift
   import npu_feed_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      shift_en,
   input  logic [7:0]                din,
   output logic [CFG_BYTES-1:0][7:0] cfg_bytes
);

   logic [CFG_BYTES-1:0][7:0] cfg_q;
   logic [CFG_BYTES-1:0][7:0] cfg_d;

   // The first byte read ends up in lane 0 after CFG_BYTES shifts.
   always_comb begin
      cfg_d = cfg_q;
      if (shift_en) begin
         cfg_d = {din, cfg_q[CFG_BYTES-1:1]};
      end
      cfg_bytes = cfg_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

endmodule

// File: rtl/npu_feed_ctrl.sv
// Read-side sequencer that loads a filter config and streams image/dense beats to the NPU lanes.
// Define NPU_FEED_PERF_EN to add the stall_cnt output.
module npu_feed_ctrl
   import npu_feed_pkg::*;
#(
   parameter int IMG_AW   = 10,
   parameter int CONV_AW  = 15,
   parameter int DENSE_AW = 15,
   parameter int LEN_W    = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [CONV_AW-1:0]  conv_base,
   input  logic [IMG_AW-1:0]   img_base,
   input  logic [DENSE_AW-1:0] dense_base,
   input  logic [LEN_W-1:0]    img_len,
   input  logic                npu_ready,
   input  logic [7:0]          read_image0,
   input  logic [7:0]          read_image1,
   input  logic [7:0]          read_image2,
   input  logic [7:0]          read_image3,
   input  logic [7:0]          read_conv,
   input  logic [7:0]          read_dense0,
   input  logic [7:0]          read_dense1,
   input  logic [7:0]          read_dense2,
   input  logic [7:0]          read_dense3,
   output logic [IMG_AW-1:0]   image_ram_addr,
   output logic [CONV_AW-1:0]  conv_ram_addr,
   output logic [DENSE_AW-1:0] dense_ram_addr,
   output logic [7:0]          DA,
   output logic [7:0]          DB,
   output logic [7:0]          DC,
   output logic [7:0]          DD,
   output logic [7:0]          DE,
   output logic [7:0]          DF,
   output logic [7:0]          DG,
   output logic [7:0]          DH,
   output logic                EN_CONFIG,
   output logic                EN_FSM,
   output logic                busy,
`ifdef NPU_FEED_PERF_EN
   output logic [15:0]         stall_cnt,
`endif
   output logic                done
);

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cfg_cnt_q, cfg_cnt_d;
   logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic                      mode_q, mode_d;
   logic [IMG_AW-1:0]         img_base_q, img_base_d;
   logic [DENSE_AW-1:0]       dense_base_q, dense_base_d;
   logic [CONV_AW-1:0]        conv_addr_q, conv_addr_d;
   logic [IMG_AW-1:0]         img_addr_q, img_addr_d;
   logic [DENSE_AW-1:0]       dense_addr_q, dense_addr_d;
   logic [CFG_BYTES-1:0][7:0] lanes_q, lanes_d;
   logic                      en_config_q, en_config_d;
   logic                      en_fsm_q, en_fsm_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      shift_en;
   logic [CFG_BYTES-1:0][7:0] cfg_bytes;

   npu_feed_cfg_shift u_cfg_shift (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (shift_en),
      .din       (read_conv),
      .cfg_bytes (cfg_bytes)
   );

   // Conv data trails its address by one cycle, so the first CFG_RD cycle carries no byte.
   assign shift_en = ((state_q == CFG_RD) && (cfg_cnt_q != '0)) || (state_q == CFG_WAIT);

   always_comb begin
      state_d      = state_q;
      cfg_cnt_d    = cfg_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      len_d        = len_q;
      mode_d       = mode_q;
      img_base_d   = img_base_q;
      dense_base_d = dense_base_q;
      conv_addr_d  = conv_addr_q;
      img_addr_d   = img_addr_q;
      dense_addr_d = dense_addr_q;
      lanes_d      = lanes_q;
      en_config_d  = 1'b0;
      en_fsm_d     = 1'b0;
      done_d       = 1'b0;

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  state_d      = CFG_RD;
                  mode_d       = mode;
                  img_base_d   = img_base;
                  dense_base_d = dense_base;
                  len_d        = img_len;
                  conv_addr_d  = conv_base;
                  cfg_cnt_d    = '0;
                  beat_cnt_d   = '0;
               end
            end
            CFG_RD: begin
               if (cfg_cnt_q == CNT_W'(CFG_BYTES - 1)) begin
                  state_d = CFG_WAIT;
               end else begin
                  cfg_cnt_d   = cfg_cnt_q + CNT_W'(1);
                  conv_addr_d = conv_addr_q + CONV_AW'(1);
               end
            end
            CFG_WAIT: begin
               lanes_d     = cfg_bytes;
               en_config_d = 1'b1;
               state_d     = CFG_OUT;
            end
            CFG_OUT: begin
               if (len_q == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d      = RD_A;
                  img_addr_d   = img_base_q;
                  dense_addr_d = dense_base_q;
               end
            end
            RD_A: begin
               if (mode_q == MODE_CONV) begin
                  state_d    = RD_B;
                  img_addr_d = img_addr_q + IMG_AW'(1);
               end else begin
                  state_d = CAP;
               end
            end
            RD_B: begin
               lanes_d[3:0] = {read_image3, read_image2, read_image1, read_image0};
               state_d      = CAP;
            end
            CAP: begin
               if (mode_q == MODE_DENSE) begin
                  lanes_d[3:0] = {read_dense3, read_dense2, read_dense1, read_dense0};
               end
               lanes_d[7:4] = {read_image3, read_image2, read_image1, read_image0};
               en_fsm_d     = 1'b1;
               state_d      = PRESENT;
            end
            PRESENT: begin
               if (!npu_ready) begin
                  en_fsm_d = 1'b1;
               end else if (beat_cnt_q == len_q - LEN_W'(1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  beat_cnt_d   = beat_cnt_q + LEN_W'(1);
                  img_addr_d   = img_base_q + IMG_AW'(beat_cnt_d);
                  dense_addr_d = dense_base_q + DENSE_AW'(beat_cnt_d);
                  state_d      = RD_A;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cfg_cnt_q    <= '0;
         beat_cnt_q   <= '0;
         len_q        <= '0;
         mode_q       <= 1'b0;
         img_base_q   <= '0;
         dense_base_q <= '0;
         conv_addr_q  <= '0;
         img_addr_q   <= '0;
         dense_addr_q <= '0;
         lanes_q      <= '0;
         en_config_q  <= 1'b0;
         en_fsm_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_cnt_q    <= cfg_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         img_base_q   <= img_base_d;
         dense_base_q <= dense_base_d;
         conv_addr_q  <= conv_addr_d;
         img_addr_q   <= img_addr_d;
         dense_addr_q <= dense_addr_d;
         lanes_q      <= lanes_d;
         en_config_q  <= en_config_d;
         en_fsm_q     <= en_fsm_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef NPU_FEED_PERF_EN
   logic [15:0] stall_q, stall_d;

   // Counts backpressure cycles of the current command, saturating instead of wrapping.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && start && !abort) begin
         stall_d = '0;
      end else if ((state_q == PRESENT) && !npu_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign image_ram_addr = img_addr_q;
   assign conv_ram_addr  = conv_addr_q;
   assign dense_ram_addr = dense_addr_q;
   assign DA             = lanes_q[0];
   assign DB             = lanes_q[1];
   assign DC             = lanes_q[2];
   assign DD             = lanes_q[3];
   assign DE             = lanes_q[4];
   assign DF             = lanes_q[5];
   assign DG             = lanes_q[6];
   assign DH             = lanes_q[7];
   assign EN_CONFIG      = en_config_q;
   assign EN_FSM         = en_fsm_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_npu_feed_ctrl.sv
// Directed self-checking bench for npu_feed_ctrl with behavioural 1-cycle-latency RAM models.
module tb_npu_feed_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic        mode;
   logic [14:0] conv_base;
   logic [9:0]  img_base;
   logic [14:0] dense_base;
   logic [9:0]  img_len;
   logic        npu_ready;
   logic [7:0]  read_image0, read_image1, read_image2, read_image3;
   logic [7:0]  read_conv;
   logic [7:0]  read_dense0, read_dense1, read_dense2, read_dense3;
   logic [9:0]  image_ram_addr;
   logic [14:0] conv_ram_addr;
   logic [14:0] dense_ram_addr;
   logic [7:0]  DA, DB, DC, DD, DE, DF, DG, DH;
   logic        EN_CONFIG, EN_FSM, busy, done;
`ifdef NPU_FEED_PERF_EN
   logic [15:0] stall_cnt;
`endif

   int testCount = 0;
   int failCount = 0;
   int consumeCount = 0;
   int doneCount = 0;

   npu_feed_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .mode           (mode),
      .conv_base      (conv_base),
      .img_base       (img_base),
      .dense_base     (dense_base),
      .img_len        (img_len),
      .npu_ready      (npu_ready),
      .read_image0    (read_image0),
      .read_image1    (read_image1),
      .read_image2    (read_image2),
      .read_image3    (read_image3),
      .read_conv      (read_conv),
      .read_dense0    (read_dense0),
      .read_dense1    (read_dense1),
      .read_dense2    (read_dense2),
      .read_dense3    (read_dense3),
      .image_ram_addr (image_ram_addr),
      .conv_ram_addr  (conv_ram_addr),
      .dense_ram_addr (dense_ram_addr),
      .DA             (DA),
      .DB             (DB),
      .DC             (DC),
      .DD             (DD),
      .DE             (DE),
      .DF             (DF),
      .DG             (DG),
      .DH             (DH),
      .EN_CONFIG      (EN_CONFIG),
      .EN_FSM         (EN_FSM),
      .busy           (busy),
`ifdef NPU_FEED_PERF_EN
      .stall_cnt      (stall_cnt),
`endif
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] convByte(input logic [14:0] a);
      if (a >= 15'h100 && a < 15'h108) return 8'(a - 15'h0FF);
      return 8'h5A;
   endfunction

   // Synchronous RAM models: data follows the address by one clock.
   always @(posedge clk) begin
      read_conv   <= convByte(conv_ram_addr);
      read_image0 <= image_ram_addr[7:0];
      read_image1 <= image_ram_addr[7:0] + 8'd1;
      read_image2 <= image_ram_addr[7:0] + 8'd2;
      read_image3 <= image_ram_addr[7:0] + 8'd3;
      read_dense0 <= dense_ram_addr[7:0] + 8'h40;
      read_dense1 <= dense_ram_addr[7:0] + 8'h41;
      read_dense2 <= dense_ram_addr[7:0] + 8'h42;
      read_dense3 <= dense_ram_addr[7:0] + 8'h43;
      if (EN_FSM === 1'b1 && npu_ready === 1'b1) consumeCount++;
      if (done === 1'b1) doneCount++;
   end

   function automatic logic [63:0] lanes();
      return {DH, DG, DF, DE, DD, DC, DB, DA};
   endfunction

   function automatic logic [127:0] allOut();
      return {20'd0, image_ram_addr, conv_ram_addr, dense_ram_addr, lanes(),
              EN_CONFIG, EN_FSM, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic skip(input int n);
      repeat (n) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues a one-cycle start, then scrambles the command inputs to prove they were latched.
   task automatic applyStimulus(input logic m, input logic [14:0] cb, input logic [9:0] ib,
                                input logic [14:0] db, input logic [9:0] len);
      mode       = m;
      conv_base  = cb;
      img_base   = ib;
      dense_base = db;
      img_len    = len;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      mode       = ~m;
      conv_base  = 15'h0;
      img_base   = 10'h155;
      dense_base = 15'h0;
      img_len    = 10'd7;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, 128'(done), 128'd1);
   endtask

   initial begin
      int doneSnap;
      int consSnap;
      reset      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      mode       = 1'b0;
      conv_base  = '0;
      img_base   = '0;
      dense_base = '0;
      img_len    = '0;
      npu_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("reset_idle", allOut(), 128'd0);
      end

      // Config load with zero beats.
      applyStimulus(1'b0, 15'h100, 10'h000, 15'h000, 10'd0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("cfg_addr", 128'(conv_ram_addr), 128'(15'h100 + 15'(i)));
         tick();
      end
      tick();
      checkOutput("cfg_strobe", {EN_CONFIG, EN_FSM, busy, done}, 4'b1010);
      checkOutput("cfg_lanes", 128'(lanes()), 128'(64'h0807060504030201));
      tick();
      checkOutput("cfg_done", {EN_CONFIG, EN_FSM, busy, done}, 4'b0011);
      tick();
      checkOutput("cfg_idle", {EN_CONFIG, EN_FSM, busy, done}, 4'b0000);

      // Conv mode with address wrap, full-speed NPU.
      applyStimulus(1'b0, 15'h100, 10'h3FE, 15'h000, 10'd2);
      skip(10);
      checkOutput("conv_addr0", 128'(image_ram_addr), 128'(10'h3FE));
      tick();
      checkOutput("conv_addr1", 128'(image_ram_addr), 128'(10'h3FF));
      skip(2);
      checkOutput("conv_beat0", {EN_FSM, lanes()}, {1'b1, 64'h020100FF_0100FFFE});
      tick();
      checkOutput("conv_addr2", {EN_FSM, image_ram_addr}, {1'b0, 10'h3FF});
      tick();
      checkOutput("conv_wrap", {EN_FSM, image_ram_addr}, {1'b0, 10'h000});
      tick();
      checkOutput("conv_gap", 128'(EN_FSM), 128'd0);
      tick();
      checkOutput("conv_beat1", {EN_FSM, lanes()}, {1'b1, 64'h03020100_020100FF});
      tick();
      checkOutput("conv_done", {EN_FSM, busy, done}, 3'b011);
      tick();

      // Dense mode with five backpressure cycles on beat 1.
      consSnap = consumeCount;
      applyStimulus(1'b1, 15'h100, 10'h010, 15'h020, 10'd3);
      skip(12);
      checkOutput("dense_beat0", {EN_FSM, lanes()}, {1'b1, 64'h13121110_63626160});
      skip(2);
      npu_ready = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         checkOutput("dense_hold", {EN_FSM, lanes()}, {1'b1, 64'h14131211_64636261});
         if (i == 5) npu_ready = 1'b1;
         tick();
      end
      checkOutput("dense_released", 128'(EN_FSM), 128'd0);
      waitDone("dense_done", 10);
      checkOutput("dense_consumes", 128'(consumeCount - consSnap), 128'd3);
`ifdef NPU_FEED_PERF_EN
      checkOutput("stall_cnt", 128'(stall_cnt), 128'd5);
`endif
      tick();

      // start together with abort in IDLE is dropped.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start_abort_idle", 128'(busy), 128'd0);

      // Abort during RD_B of beat 1, then a clean restart.
      doneSnap = doneCount;
      applyStimulus(1'b0, 15'h100, 10'h020, 15'h000, 10'd3);
      skip(15);
      checkOutput("abort_rdb_addr", {busy, image_ram_addr}, {1'b1, 10'h022});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_out", {EN_FSM, EN_CONFIG, busy, done}, 4'b0000);
      checkOutput("abort_lanes", 128'(lanes()), 128'(64'h24232221_23222120));
      skip(5);
      checkOutput("abort_no_done", 128'(doneCount - doneSnap), 128'd0);
      applyStimulus(1'b0, 15'h100, 10'h040, 15'h000, 10'd1);
      waitDone("restart_done", 30);
      checkOutput("restart_lanes", 128'(lanes()), 128'(64'h44434241_43424140));
      tick();

      // Asynchronous reset while presenting a stalled beat.
      npu_ready = 1'b0;
      applyStimulus(1'b1, 15'h100, 10'h010, 15'h020, 10'd2);
      skip(12);
      checkOutput("pre_reset_present", 128'(EN_FSM), 128'd1);
      reset = 1'b0;
      #2;
      checkOutput("async_reset", allOut(), 128'd0);
      reset = 1'b1;
      npu_ready = 1'b1;
      tick();
      checkOutput("post_reset_idle", {busy, EN_FSM, done}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/npu_feed_ctrl.md
Name: npu_feed_ctrl

Overview:
- Read-side sequencer for the image, conv and dense RAM banks that feeds the NPU's eight byte lanes DA..DH.
- On a start command it loads one 8-byte filter configuration from conv RAM and presents it with EN_CONFIG.
- It then streams img_len data beats to the NPU with EN_FSM, honouring NPU backpressure.
- It owns the read ports (addr_b side) of all RAMs; the write path is untouched.

Parameters:
- IMG_AW, 10, image RAM address width
- CONV_AW, 15, conv RAM address width
- DENSE_AW, 15, dense RAM address width
- LEN_W, 10, beat-count width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command pulse; ignored unless idle
- abort  in  1  synchronous abort to IDLE
- mode  in  1  0 = conv (sliding window), 1 = dense
- conv_base  in  CONV_AW  first filter byte address
- img_base  in  IMG_AW  first image address
- dense_base  in  DENSE_AW  first dense address
- img_len  in  LEN_W  number of beats
- npu_ready  in  1  NPU accepts the presented beat
- read_image0..3  in  8 each  image bank read data
- read_conv  in  8  conv RAM read data
- read_dense0..3  in  8 each  dense bank read data
- image_ram_addr  out  IMG_AW  image read address (all banks)
- conv_ram_addr  out  CONV_AW  conv read address
- dense_ram_addr  out  DENSE_AW  dense read address
- DA..DH  out  8 each  NPU byte lanes
- EN_CONFIG  out  1  filter-config strobe
- EN_FSM  out  1  data-beat valid
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters 0.
- RAMs are synchronous with 1-cycle read latency: an address driven in cycle n gives data in cycle n+1.
- start, mode, bases and img_len are sampled in IDLE on start=1 and latched; later input changes have no effect.
- Config sequence (cycle 0 = start sampled):
  - CFG_RD, cycles 1..8: conv_ram_addr = conv_base+i, i = 0..7.
  - Data is shifted into an 8-byte config register during cycles 2..9; cycle 9 is CFG_WAIT.
  - CFG_OUT, cycle 10: DA = byte0 .. DH = byte7, EN_CONFIG=1 for exactly one cycle. No backpressure on config.
- Conv beat k (k = 0..img_len-1):
  - RD_A: image_ram_addr = img_base+k.
  - RD_B: image_ram_addr = img_base+k+1; capture read_image0..3 into DA..DD.
  - CAP: capture read_image0..3 into DE..DH.
  - PRESENT: EN_FSM=1.
- Dense beat k:
  - RD: image_ram_addr = img_base+k, dense_ram_addr = dense_base+k.
  - CAP: DA..DD = read_dense0..3, DE..DH = read_image0..3.
  - PRESENT: EN_FSM=1.
- Handshake:
  - A beat is consumed on a cycle with EN_FSM=1 and npu_ready=1.
  - While npu_ready=0, stay in PRESENT with DA..DH and EN_FSM held stable.
  - Minimum beat period: conv 4 cycles, dense 3.
- After consuming the last beat: DONE state for 1 cycle (done=1, busy=1), then IDLE.
- img_len=0: CFG_OUT goes straight to DONE; no EN_FSM.
- Addresses wrap modulo 2^AW; conv img_base+k+1 wraps silently.
- EN_FSM and EN_CONFIG are never high in the same cycle.
- abort=1 in any non-IDLE state: next cycle IDLE, EN_FSM/EN_CONFIG/busy=0, DA..DH keep their last values, no done. abort has priority over npu_ready.
- start while busy: ignored. start and abort together in IDLE: abort wins (stay IDLE).
- Mid-operation reset returns to the reset values immediately.
- busy = (state != IDLE).

Optional Feature:
- Macro NPU_FEED_PERF_EN.
- When defined, add output stall_cnt [15:0]:
  - Cleared on start accept.
  - Increments each cycle in PRESENT with npu_ready=0; saturates at 16'hFFFF.
  - Holds its value in IDLE.
- When undefined: no port and no logic.

Decomposition:
- Shared package npu_feed_pkg holds:
  - the state enum (IDLE, CFG_RD, CFG_WAIT, CFG_OUT, RD_A, RD_B, CAP, PRESENT, DONE);
  - the constant CFG_BYTES=8;
  - the mode encodings.
- One natural sub-module, npu_feed_cfg_shift: the 8-byte shift register that loads serially from read_conv and exposes lanes in parallel.

Test Plan:
- Reset released, no start: all outputs 0, busy=0 for 20 cycles.
- conv_base=0x100 holding bytes 1..8, img_len=0: conv_ram_addr steps 0x100..0x107; EN_CONFIG=1 at cycle 10 with DA..DH = 1..8; done pulses at cycle 11.
- Conv mode, img_base=0x3FE, img_len=2, npu_ready=1, image bank j at addr a = a[7:0]+j:
  - Beat 0: DA..DD = FE,FF,00,01 and DE..DH = FF,00,01,02.
  - Beat 1 uses addresses 0x3FF/0x000 (wrap).
  - Consecutive EN_FSM pulses are 4 cycles apart.
- Dense mode, img_len=3, npu_ready held low for 5 cycles during beat 1: EN_FSM and lanes stay stable for 6 cycles; exactly 3 consumes; with NPU_FEED_PERF_EN, stall_cnt=5.
- Abort during RD_B of beat 1: next cycle busy=0 and EN_FSM=0; done never asserts; a new start then runs cleanly.
- Async reset asserted mid-PRESENT: outputs go to 0 without waiting for a clock edge; state is IDLE after release.
